// File: rtl/store_write_unit_pkg.sv
// Shared memory-side types and the store lane packer.
// lane_pack places right-aligned store data into the byte-bank lanes that a WORD load reads.
package store_write_unit_pkg;

  localparam int memory_bits = 10;
  localparam int memory_size = 1 << memory_bits;

  typedef logic [31:0] word;
  typedef logic [31:0] word_address;
  typedef logic [3:0]  byte_enable;
  typedef logic [29:0] word_index;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } load_type;

  typedef struct packed {
    word_index  idx;
    word        data;
    byte_enable byte_en;
  } store_entry;

  typedef struct packed {
    word        data;
    byte_enable byte_en;
    logic       misaligned;
  } lane_pack_t;

  // Bank k sits in bits [31-8k -: 8]; ~offset equals 3-offset for a 2-bit offset.
  function automatic lane_pack_t lane_pack(input logic [1:0] offset, input load_type kind,
                                           input word value);
    lane_pack_t r;
    r = '0;
    case (kind)
      WORD: begin
        r.misaligned = (offset != 2'b00);
        r.data       = value;
        r.byte_en    = 4'b1111;
      end
      HALFWORD: begin
        r.misaligned = offset[0];
        r.data       = {16'h0000, value[15:0]} << {~offset[1], 4'b0000};
        r.byte_en    = 4'b0011 << offset;
      end
      BYTE: begin
        r.misaligned = 1'b0;
        r.data       = {24'h000000, value[7:0]} << {~offset, 3'b000};
        r.byte_en    = 4'b0001 << offset;
      end
      default: r.misaligned = 1'b1;
    endcase
    if (r.misaligned) begin
      r.data    = '0;
      r.byte_en = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/store_write_unit_if.sv
// Store request, bank write and hazard probe signals of the store write unit.
// master = memory stage / banks / hazard unit side, slave = the store write unit.
interface store_write_unit_if
  import store_write_unit_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MEM_BITS = memory_bits
);

  logic                   req_valid;
  logic                   req_ready;
  word_address            req_addr;
  word                    req_data;
  load_type               req_type;
  logic                   fault;

  logic                   mem_wr_en;
  logic                   mem_wr_ready;
  logic [MEM_BITS-3:0]    mem_wr_word_addr;
  word                    mem_wr_data;
  byte_enable             mem_wr_byte_en;

  word_address            probe_addr;
  logic                   probe_hit;

  logic [$clog2(DEPTH):0] count;
  logic                   empty;

  modport master (
    output req_valid, req_addr, req_data, req_type, mem_wr_ready, probe_addr,
    input  req_ready, fault, mem_wr_en, mem_wr_word_addr, mem_wr_data, mem_wr_byte_en,
           probe_hit, count, empty
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_type, mem_wr_ready, probe_addr,
    output req_ready, fault, mem_wr_en, mem_wr_word_addr, mem_wr_data, mem_wr_byte_en,
           probe_hit, count, empty
  );

endinterface

// File: rtl/store_write_unit_store_queue.sv
// In-order DEPTH-entry FIFO of store entries with a parallel word-index match over valid entries.
// Head is presented from registered state; pushes when full and pops when empty are ignored.
module store_queue
  import store_write_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  store_entry             push_entry,
  input  logic                   pop,
  output store_entry             head_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  input  word_index              match_idx,
  output logic                   match_hit
);

  localparam int PW = $clog2(DEPTH);

  store_entry         mem_q [DEPTH];
  store_entry         mem_d [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [PW:0]        count_q, count_d;
  logic               do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_push = push && !full;
    do_pop  = pop && !empty;
    // head==tail only when empty or full, so push and pop never touch the same slot
    if (do_push) begin
      mem_d[tail_q]   = push_entry;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end
    if (do_pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_entry = empty ? '0 : mem_q[head_q];

  always_comb begin
    match_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].idx == match_idx)) begin
        match_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_write_unit.sv
// Store write unit: alignment check, lane packing and in-order queueing of stores to the byte banks.
// Accepted store reaches the banks the next cycle; req_ready = !full, head holds while mem_wr_ready=0.
module store_write_unit
  import store_write_unit_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MEM_BITS = memory_bits
) (
  input logic clk,
  input logic reset,
  store_write_unit_if.slave bus
);

  lane_pack_t             packed_req;
  store_entry             new_entry;
  store_entry             head_entry;
  word_index              req_idx;
  word_index              probe_idx;
  logic                   handshake;
  logic                   q_push, q_pop;
  logic                   q_full, q_empty, q_hit;
  logic [$clog2(DEPTH):0] q_count;
  logic                   fault_q, fault_d;
  logic                   unused_bits;

  always_comb begin
    packed_req = lane_pack(bus.req_addr[1:0], bus.req_type, bus.req_data);
    handshake  = bus.req_valid && !q_full;
    req_idx    = '0;
    req_idx[MEM_BITS-3:0]   = bus.req_addr[MEM_BITS-1:2];
    probe_idx  = '0;
    probe_idx[MEM_BITS-3:0] = bus.probe_addr[MEM_BITS-1:2];
    new_entry  = '{idx: req_idx, data: packed_req.data, byte_en: packed_req.byte_en};
    // misaligned requests are consumed so the pipeline never stalls on them
    q_push     = handshake && !packed_req.misaligned;
    fault_d    = handshake && packed_req.misaligned;
    q_pop      = !q_empty && bus.mem_wr_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  store_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .push_entry (new_entry),
    .pop        (q_pop),
    .head_entry (head_entry),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty),
    .match_idx  (probe_idx),
    .match_hit  (q_hit)
  );

  assign bus.req_ready        = !q_full;
  assign bus.fault            = fault_q;
  assign bus.mem_wr_en        = !q_empty;
  assign bus.mem_wr_word_addr = head_entry.idx[MEM_BITS-3:0];
  assign bus.mem_wr_data      = head_entry.data;
  assign bus.mem_wr_byte_en   = head_entry.byte_en;
  assign bus.probe_hit        = q_hit;
  assign bus.count            = q_count;
  assign bus.empty            = q_empty;

  assign unused_bits = ^{bus.req_addr[31:MEM_BITS], bus.probe_addr[31:MEM_BITS],
                         bus.probe_addr[1:0], head_entry.idx[29:MEM_BITS-2]};

endmodule
